dmem_responder: RTL

- Word-addressed data memory that answers load/store requests from the multicycle datapath.
- The datapath side is the initiator: it issues a request with address, write enable and write data. This block is the responder: it accepts the request, inserts programmable wait states, commits the write or returns read data, then acknowledges.
- Lets the datapath controller model real memory latency instead of a zero-wait combinational DMem.

---
 rtl/dmem_responder.sv | 118 +++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Word-addressed data memory with programmable wait states and a one-cycle ack.
// Accepts one request at a time; the access commits on the edge that enters RESP.
module dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state, next_state;
  logic [3:0]              wait_cnt;
  logic                    lat_we;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [DATA_WIDTH-1:0]   lat_wdata;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;

  logic                    accept;
  logic                    commit;
  logic                    c_we;
  logic                    c_err;
  logic [ADDR_WIDTH-1:0]   c_addr;
  logic [DATA_WIDTH-1:0]   c_wdata;
  logic [DEPTH_LOG2-1:0]   c_index;

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            next_state = S_RESP;
            commit     = 1'b1;
          end else begin
            next_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt <= 4'd1) begin
          next_state = S_RESP;
          commit     = 1'b1;
        end
      end
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // With zero wait states the commit happens on the accepting edge, so use the live inputs.
  always_comb begin
    c_we    = (state == S_IDLE) ? we    : lat_we;
    c_addr  = (state == S_IDLE) ? addr  : lat_addr;
    c_wdata = (state == S_IDLE) ? wdata : lat_wdata;
    c_index = c_addr[DEPTH_LOG2-1:0];
    c_err   = ({1'b0, c_addr} >= ADDR_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        wait_cnt  <= WAIT_INIT;
        lat_we    <= we;
        lat_addr  <= addr;
        lat_wdata <= wdata;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (commit) begin
        err_q   <= c_err;
        rdata_q <= c_err ? '0 : (c_we ? c_wdata : mem[c_index]);
      end
    end
  end

  // Reset outranks commit, so a store aborted by reset never reaches the array.
  always_ff @(posedge clk) begin
    if (reset && commit && c_we && !c_err) begin
      mem[c_index] <= c_wdata;
    end
  end

  assign ready = (state == S_IDLE);
  assign ack   = (state == S_RESP);
  assign err   = ack & err_q;
  assign rdata = rdata_q;

endmodule
